uart_receiver: RTL and testbench

UART receive path for the tiny-tapeout UART top: the counterpart of the existing `Transmitter`, recovering 8N1 frames from a serial line into parallel bytes. Samples an asynchronous `RxD` through a two-flop synchronizer and validates the start bit at mid-bit. Data bits are sampled at bit centres, LSB first, and each byte lands in a one-entry holding register with a valid/acknowledge handshake. Sits beside `Transmitter` in the top level and shares its clock, reset and bit-rate parameter.

---
 rtl/uart_receiver.sv | 168 ++++++++++++++++
 tb/tb_uart_receiver.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver
// Receive half of the UART: recovers 8N1 frames from an asynchronous serial
// line and presents each byte in a one-entry holding register.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 4)
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   RxD        asynchronous serial input, idle high
//   rx_ack     consumer has taken rx_data; clears rx_valid and overrun
//   rx_data    last accepted byte
//   rx_valid   rx_data holds an unread byte
//   overrun    sticky; a finished byte was dropped while rx_valid was set
//   frame_err  one-cycle pulse when the stop bit is sampled low
//   busy       high while a frame is being received
module uart_receiver #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       overrun,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] START_END = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cycle_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             s1;
  logic             s2;
  logic             flushed;
  logic             armed;

  // Two-flop synchronizer; presets to the idle level so reset never looks
  // like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= RxD;
      s2 <= s1;
    end
  end

  // After reset the synchronizer holds preset values, so a real high level
  // on the line must be observed before a falling edge can start a frame.
  // flushed marks that s1 holds a genuine line sample; armed latches once
  // such a sample was high. This keeps the tail of an abandoned frame from
  // being mistaken for a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      flushed <= 1'b0;
      armed   <= 1'b0;
    end else begin
      flushed <= 1'b1;
      if (flushed && s1) armed <= 1'b1;
    end
  end

  // Receive FSM plus holding register. An rx_ack clears the flags first;
  // an accept in the same cycle then overrides rx_valid, so an ack that
  // collides with a new byte hands the new byte over instead of losing it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cycle_cnt <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (rx_ack) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end

      case (state)
        IDLE: begin
          cycle_cnt <= '0;
          if (armed && !s2) begin
            state <= START;
            busy  <= 1'b1;
          end
        end

        // Re-check the line at mid start bit; a high level means a glitch.
        START: begin
          if (cycle_cnt == START_END) begin
            cycle_cnt <= '0;
            bit_idx   <= '0;
            if (s2) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
          end
        end

        // Counting from mid start bit, every full bit period lands on the
        // centre of the next data bit.
        DATA: begin
          if (cycle_cnt == BIT_END) begin
            cycle_cnt          <= '0;
            shift_reg[bit_idx] <= s2;
            bit_idx            <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
          end
        end

        // Leaving at the stop-bit centre lets a start bit that follows
        // immediately be caught on time.
        STOP: begin
          if (cycle_cnt == BIT_END) begin
            cycle_cnt <= '0;
            state     <= IDLE;
            busy      <= 1'b0;
            if (s2) begin
              if (!rx_valid || rx_ack) begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver
// Self-checking bench for uart_receiver. A timestamp-based reference model
// keeps a history of every line sample and derives each frame's outcome
// from the bit-centre sample times; it is compared against the DUT outputs
// every cycle. Directed scenarios add hand-computed literal expectations.
module tb_uart_receiver;

  localparam int N    = 16;
  localparam int H    = N / 2;
  localparam int MAXC = 30000;

  logic       clk = 1'b0;
  logic       rst;
  logic       RxD;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       overrun;
  logic       frame_err;
  logic       busy;

  uart_receiver #(.CLKS_PER_BIT(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .RxD       (RxD),
    .rx_ack    (rx_ack),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .overrun   (overrun),
    .frame_err (frame_err),
    .busy      (busy)
  );

  // Free-running 100 MHz-style clock.
  always #5 clk = ~clk;

  // Count rising edges and capture the inputs exactly as the DUT sees them
  // at each edge, so the model can process that edge later at the negedge.
  int   edge_cnt = 0;
  logic rx_s, rst_s, ack_s;
  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    rx_s     <= RxD;
    rst_s    <= rst;
    ack_s    <= rx_ack;
  end

  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)",
               name, act, exp, edge_cnt);
    end
  endtask

  // Reference model state. rhist[e] is the line level sampled at edge e.
  // A frame is identified only by fs, the edge at which reception began;
  // every later decision reads the line sample two edges before its own
  // edge (synchronizer delay) at a fixed offset from fs.
  bit         rhist [MAXC];
  int         rst_edge = -1000;
  int         fs = -1;
  bit         seen_high = 1'b0;
  bit         model_on = 1'b0;
  logic [7:0] m_data = 8'h00;
  bit         m_valid = 1'b0, m_ov = 1'b0, m_fe = 1'b0, m_busy = 1'b0;

  task automatic model_step(input int c);
    int         ev;
    logic [7:0] b;
    bit         old_valid;
    rhist[c] = rx_s;
    if (rst_s === 1'b1) begin
      rst_edge  = c;
      fs        = -1;
      seen_high = 1'b0;
      m_data    = 8'h00;
      m_valid   = 1'b0;
      m_ov      = 1'b0;
      m_fe      = 1'b0;
      m_busy    = 1'b0;
      model_on  = 1'b1;
      return;
    end
    if (!model_on) return;
    m_fe      = 1'b0;
    old_valid = m_valid;
    if (ack_s === 1'b1) begin
      m_valid = 1'b0;
      m_ov    = 1'b0;
    end
    ev = c - 2;
    if (fs < 0) begin
      if (ev > rst_edge) begin
        if (rhist[ev]) seen_high = 1'b1;
        else if (seen_high) fs = c;
      end
    end else if (c == fs + H) begin
      if (rhist[ev]) fs = -1;
    end else if (c == fs + H + 9 * N) begin
      for (int i = 0; i < 8; i++) b[i] = rhist[fs + H + (i + 1) * N - 2];
      if (rhist[ev]) begin
        if (!old_valid || ack_s === 1'b1) begin
          m_data  = b;
          m_valid = 1'b1;
        end else begin
          m_ov = 1'b1;
        end
      end else begin
        m_fe = 1'b1;
      end
      fs = -1;
    end
    m_busy = (fs >= 0);
  endtask

  // Compare process: advance the model by one edge, compare all outputs,
  // and keep a few event monitors used by the directed literal checks.
  int valid_rise = -1;
  int fe_edge    = -1;
  int fe_cnt     = 0;
  int busy_cnt   = 0;
  bit prev_valid = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (edge_cnt >= MAXC) begin
        $display("[TB] FAIL cycle_budget: got %0d edges, limit %0d", edge_cnt, MAXC);
        $fatal(1, "[TB] cycle budget exhausted");
      end
      model_step(edge_cnt);
      if (model_on)
        checkOutput("cycle_outputs",
                    {20'h0, busy, frame_err, overrun, rx_valid, rx_data},
                    {20'h0, m_busy, m_fe, m_ov, m_valid, m_data});
      if (rx_valid === 1'b1 && !prev_valid) valid_rise = edge_cnt;
      prev_valid = (rx_valid === 1'b1);
      if (frame_err === 1'b1) begin
        fe_cnt++;
        fe_edge = edge_cnt;
      end
      if (busy === 1'b1) busy_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearMonitors();
    valid_rise = -1;
    fe_edge    = -1;
    fe_cnt     = 0;
    busy_cnt   = 0;
  endtask

  // Sends one 8N1 frame; last_e0 is the edge that first samples the start bit.
  int last_e0 = 0;
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
    last_e0 = edge_cnt + 1;
    RxD = 1'b0;
    repeat (N) step();
    for (int i = 0; i < 8; i++) begin
      RxD = data[i];
      repeat (N) step();
    end
    RxD = stop_bit;
    repeat (N) step();
    RxD = 1'b1;
  endtask

  task automatic pulseAck();
    rx_ack = 1'b1;
    step();
    rx_ack = 1'b0;
  endtask

  // Random acknowledge generator, active only during the random phase.
  bit rand_ack_en = 1'b0;
  initial begin
    forever begin
      step();
      if (rand_ack_en) rx_ack = ($urandom_range(0, 5) == 0);
    end
  end

  // Directed scenarios followed by randomized traffic.
  int e0;
  initial begin
    rst    = 1'b1;
    RxD    = 1'b1;
    rx_ack = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    checkOutput("reset_rx_data", rx_data, 8'h00);
    checkOutput("reset_rx_valid", rx_valid, 1'b0);
    checkOutput("reset_overrun", overrun, 1'b0);
    checkOutput("reset_frame_err", frame_err, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    repeat (4) step();

    $display("[TB] glitch");
    clearMonitors();
    RxD = 1'b0;
    repeat (3) step();
    RxD = 1'b1;
    repeat (2 * N) step();
    checkOutput("glitch_busy_seen", busy_cnt > 0, 1);
    checkOutput("glitch_rx_valid", rx_valid, 1'b0);
    checkOutput("glitch_frame_err", fe_cnt, 0);

    $display("[TB] framing error");
    clearMonitors();
    applyStimulus(8'h3C, 1'b0);
    repeat (2 * N) step();
    checkOutput("ferr_pulse_count", fe_cnt, 1);
    checkOutput("ferr_pulse_edge", fe_edge, last_e0 + 154);
    checkOutput("ferr_rx_valid", rx_valid, 1'b0);
    checkOutput("ferr_rx_data", rx_data, 8'h00);

    $display("[TB] normal byte");
    clearMonitors();
    applyStimulus(8'hA5, 1'b1);
    repeat (4) step();
    checkOutput("a5_latency", valid_rise, last_e0 + 154);
    checkOutput("a5_rx_data", rx_data, 8'hA5);
    checkOutput("a5_rx_valid", rx_valid, 1'b1);
    checkOutput("a5_frame_err", fe_cnt, 0);
    pulseAck();
    checkOutput("a5_ack_clear", rx_valid, 1'b0);

    $display("[TB] overrun");
    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h22, 1'b1);
    repeat (4) step();
    checkOutput("ovr_rx_data", rx_data, 8'h11);
    checkOutput("ovr_overrun", overrun, 1'b1);
    checkOutput("ovr_rx_valid", rx_valid, 1'b1);
    pulseAck();
    checkOutput("ovr_ack_valid", rx_valid, 1'b0);
    checkOutput("ovr_ack_overrun", overrun, 1'b0);

    $display("[TB] ack collision");
    applyStimulus(8'h11, 1'b1);
    repeat (2) step();
    e0 = edge_cnt + 1;
    fork
      applyStimulus(8'h22, 1'b1);
      begin
        while (edge_cnt < e0 + 153) step();
        rx_ack = 1'b1;
        step();
        rx_ack = 1'b0;
      end
    join
    repeat (2) step();
    checkOutput("col_rx_data", rx_data, 8'h22);
    checkOutput("col_rx_valid", rx_valid, 1'b1);
    checkOutput("col_overrun", overrun, 1'b0);

    $display("[TB] reset mid-frame");
    e0 = edge_cnt + 1;
    fork
      applyStimulus(8'hFF, 1'b1);
      begin
        while (edge_cnt < e0 + 84) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("rmf_rx_data", rx_data, 8'h00);
        checkOutput("rmf_rx_valid", rx_valid, 1'b0);
        checkOutput("rmf_overrun", overrun, 1'b0);
        checkOutput("rmf_frame_err", frame_err, 1'b0);
        checkOutput("rmf_busy", busy, 1'b0);
      end
    join
    clearMonitors();
    applyStimulus(8'h5A, 1'b1);
    repeat (4) step();
    checkOutput("rmf_5a_rx_data", rx_data, 8'h5A);
    checkOutput("rmf_5a_rx_valid", rx_valid, 1'b1);
    checkOutput("rmf_5a_frame_err", fe_cnt, 0);
    pulseAck();

    $display("[TB] random traffic");
    rand_ack_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        RxD = 1'b0;
        repeat ($urandom_range(1, 12)) step();
        RxD = 1'b1;
        repeat ($urandom_range(N, 2 * N)) step();
      end else begin
        applyStimulus(8'($urandom_range(0, 255)), $urandom_range(0, 7) != 0);
        repeat ($urandom_range(0, 30)) step();
      end
    end
    rand_ack_en = 1'b0;
    rx_ack = 1'b0;
    repeat (12 * N) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
